pong_match_ctrl: RTL and testbench

Parametrised match controller for the Pong game, the successor of the fixed two-player game core. It adds selectable 2-player or player-vs-CPU mode, a score limit with game-over/winner reporting, and a post-point hold with re-serve. The block runs on a tile grid, updates once per frame, and emits registered per-pixel draw flags and scores for the colour/porch stage downstream.

---
 rtl/pong_match_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_pong_match_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match_ctrl.sv
// Pong match controller: tile-grid ball and paddle state stepped once per frame, with
// 2-player / CPU modes, score limit, post-point hold and registered per-pixel draw flags.
module pong_match_ctrl #(
    parameter int c_ACTIVE_COLS     = 640,
    parameter int c_ACTIVE_ROWS     = 480,
    parameter int c_TILE            = 16,
    parameter int c_PADDLE_HEIGHT   = 6,
    parameter int c_FRAMES_PER_MOVE = 4,
    parameter int c_PADDLE_FRAMES   = 2,
    parameter int c_POINT_FRAMES    = 60,
    parameter int c_SCORE_LIMIT     = 9,
    parameter int c_SCORE_WIDTH     = 4
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst_L,
    input  logic                     i_Frame_Start,
    input  logic [9:0]               i_Col_Count,
    input  logic [9:0]               i_Row_Count,
    input  logic                     i_Game_Start,
    input  logic                     i_Mode,
    input  logic                     i_Paddle_Up_P1,
    input  logic                     i_Paddle_Dn_P1,
    input  logic                     i_Paddle_Up_P2,
    input  logic                     i_Paddle_Dn_P2,
    output logic                     o_Draw_Ball,
    output logic                     o_Draw_Paddle_P1,
    output logic                     o_Draw_Paddle_P2,
    output logic [c_SCORE_WIDTH-1:0] o_Score_P1,
    output logic [c_SCORE_WIDTH-1:0] o_Score_P2,
    output logic [1:0]               o_State,
    output logic [1:0]               o_Winner
);
    localparam int c_GW    = c_ACTIVE_COLS / c_TILE;
    localparam int c_GH    = c_ACTIVE_ROWS / c_TILE;
    localparam int c_SHIFT = $clog2(c_TILE);
    localparam int c_XW    = $clog2(c_GW);
    localparam int c_YW    = $clog2(c_GH);
    localparam int c_BW    = $clog2(c_FRAMES_PER_MOVE + 1);
    localparam int c_PW    = $clog2(c_PADDLE_FRAMES + 1);
    localparam int c_TW    = $clog2(c_POINT_FRAMES + 1);

    localparam logic [c_XW-1:0]          c_X_CTR = c_XW'(c_GW / 2);
    localparam logic [c_YW-1:0]          c_Y_CTR = c_YW'(c_GH / 2);
    localparam logic [c_XW-1:0]          c_X_P1  = c_XW'(1);
    localparam logic [c_XW-1:0]          c_X_P2  = c_XW'(c_GW - 2);
    localparam logic [c_YW-1:0]          c_Y_MAX = c_YW'(c_GH - 1);
    localparam logic [c_YW-1:0]          c_P_MAX = c_YW'(c_GH - c_PADDLE_HEIGHT);
    localparam logic [c_YW-1:0]          c_P_CTR = c_YW'((c_GH - c_PADDLE_HEIGHT) / 2);
    localparam logic [c_SCORE_WIDTH-1:0] c_LIMIT = c_SCORE_WIDTH'(c_SCORE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_RUNNING   = 2'b01,
        S_POINT     = 2'b10,
        S_GAME_OVER = 2'b11
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [c_XW-1:0]          r_ball_x, w_ball_x_nxt;
    logic [c_YW-1:0]          r_ball_y, w_ball_y_nxt;
    logic                     r_dir_x, w_dir_x_nxt, r_dir_y, w_dir_y_nxt;
    logic [c_YW-1:0]          r_p1_y, w_p1_y_nxt, r_p2_y, w_p2_y_nxt;
    logic [c_SCORE_WIDTH-1:0] r_score_p1, w_score_p1_nxt, r_score_p2, w_score_p2_nxt;
    logic [1:0]               r_winner, w_winner_nxt;
    logic [c_BW-1:0]          r_ball_cnt, w_ball_cnt_nxt;
    logic [c_PW-1:0]          r_pad_cnt, w_pad_cnt_nxt;
    logic [c_TW-1:0]          r_point_cnt, w_point_cnt_nxt;
    logic                     r_start_req, w_start_req_nxt;
    logic                     r_draw_ball, r_draw_p1, r_draw_p2;

    function automatic logic [c_SCORE_WIDTH-1:0] sat_inc(input logic [c_SCORE_WIDTH-1:0] s);
        return (&s) ? s : s + 1'b1;
    endfunction

    logic                     w_start, w_pad_tick, w_ball_tick, w_dy, w_hit_p1, w_hit_p2;
    logic                     w_miss_p1, w_miss_p2, w_p1_up, w_p1_dn, w_p2_up, w_p2_dn;
    logic [c_YW:0]            w_ball_y_e, w_p1_hi, w_p2_hi, w_p2_mid;
    logic [c_SCORE_WIDTH-1:0] w_inc_p1, w_inc_p2;

    // A start request seen between frame pulses is held until the next frame update.
    assign w_start     = i_Game_Start || r_start_req;
    assign w_pad_tick  = (r_pad_cnt == c_PW'(c_PADDLE_FRAMES - 1));
    assign w_ball_tick = (r_ball_cnt == c_BW'(c_FRAMES_PER_MOVE - 1));
    assign w_dy        = r_dir_y ^ ((r_ball_y == '0 && !r_dir_y) || (r_ball_y == c_Y_MAX && r_dir_y));
    assign w_ball_y_e  = {1'b0, r_ball_y};
    assign w_p1_hi     = {1'b0, r_p1_y} + (c_YW+1)'(c_PADDLE_HEIGHT - 1);
    assign w_p2_hi     = {1'b0, r_p2_y} + (c_YW+1)'(c_PADDLE_HEIGHT - 1);
    assign w_p2_mid    = {1'b0, r_p2_y} + (c_YW+1)'(c_PADDLE_HEIGHT / 2);
    assign w_hit_p1    = (w_ball_y_e >= {1'b0, r_p1_y}) && (w_ball_y_e <= w_p1_hi);
    assign w_hit_p2    = (w_ball_y_e >= {1'b0, r_p2_y}) && (w_ball_y_e <= w_p2_hi);
    assign w_miss_p1   = (r_ball_x == c_X_P1) && !r_dir_x && !w_hit_p1;
    assign w_miss_p2   = (r_ball_x == c_X_P2) && r_dir_x && !w_hit_p2;
    assign w_inc_p1    = sat_inc(r_score_p1);
    assign w_inc_p2    = sat_inc(r_score_p2);
    assign w_p1_up     = i_Paddle_Up_P1 && !i_Paddle_Dn_P1;
    assign w_p1_dn     = i_Paddle_Dn_P1 && !i_Paddle_Up_P1;
    assign w_p2_up     = i_Mode ? (w_ball_y_e < w_p2_mid) : (i_Paddle_Up_P2 && !i_Paddle_Dn_P2);
    assign w_p2_dn     = i_Mode ? (w_ball_y_e > w_p2_mid) : (i_Paddle_Dn_P2 && !i_Paddle_Up_P2);

    always_comb begin
        // NOTE: every next-state value defaults to the current one, so no branch infers a latch.
        w_state_nxt     = r_state;
        w_ball_x_nxt    = r_ball_x;
        w_ball_y_nxt    = r_ball_y;
        w_dir_x_nxt     = r_dir_x;
        w_dir_y_nxt     = r_dir_y;
        w_p1_y_nxt      = r_p1_y;
        w_p2_y_nxt      = r_p2_y;
        w_score_p1_nxt  = r_score_p1;
        w_score_p2_nxt  = r_score_p2;
        w_winner_nxt    = r_winner;
        w_ball_cnt_nxt  = r_ball_cnt;
        w_pad_cnt_nxt   = r_pad_cnt;
        w_point_cnt_nxt = r_point_cnt;
        w_start_req_nxt = 1'b0;

        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (!i_Frame_Start) begin
                    w_start_req_nxt = w_start;
                end else if (w_start) begin
                    w_state_nxt     = S_RUNNING;
                    w_ball_x_nxt    = c_X_CTR;
                    w_ball_y_nxt    = c_Y_CTR;
                    w_dir_x_nxt     = 1'b1;
                    w_dir_y_nxt     = 1'b1;
                    w_p1_y_nxt      = c_P_CTR;
                    w_p2_y_nxt      = c_P_CTR;
                    w_score_p1_nxt  = '0;
                    w_score_p2_nxt  = '0;
                    w_winner_nxt    = 2'b00;
                    w_ball_cnt_nxt  = '0;
                    w_pad_cnt_nxt   = '0;
                    w_point_cnt_nxt = '0;
                end
            end
            S_RUNNING: begin
                if (i_Frame_Start) begin
                    w_pad_cnt_nxt  = w_pad_tick ? '0 : r_pad_cnt + 1'b1;
                    w_ball_cnt_nxt = w_ball_tick ? '0 : r_ball_cnt + 1'b1;
                    if (w_pad_tick) begin
                        if (w_p1_up && r_p1_y != '0)         w_p1_y_nxt = r_p1_y - 1'b1;
                        else if (w_p1_dn && r_p1_y != c_P_MAX) w_p1_y_nxt = r_p1_y + 1'b1;
                        if (w_p2_up && r_p2_y != '0)         w_p2_y_nxt = r_p2_y - 1'b1;
                        else if (w_p2_dn && r_p2_y != c_P_MAX) w_p2_y_nxt = r_p2_y + 1'b1;
                    end
                    if (w_ball_tick) begin
                        w_dir_y_nxt  = w_dy;
                        w_ball_y_nxt = w_dy ? r_ball_y + 1'b1 : r_ball_y - 1'b1;
                        if (r_ball_x == c_X_P1 && !r_dir_x) begin
                            w_dir_x_nxt  = 1'b1;
                            w_ball_x_nxt = w_hit_p1 ? c_X_P1 + 1'b1 : '0;
                        end else if (r_ball_x == c_X_P2 && r_dir_x) begin
                            w_dir_x_nxt  = 1'b0;
                            w_ball_x_nxt = w_hit_p2 ? c_X_P2 - 1'b1 : c_X_P2 + 1'b1;
                        end else begin
                            w_ball_x_nxt = r_dir_x ? r_ball_x + 1'b1 : r_ball_x - 1'b1;
                        end
                        // After a miss, the direction left in w_dir_x_nxt is the serve direction.
                        if (w_miss_p1 || w_miss_p2) begin
                            w_ball_cnt_nxt  = '0;
                            w_pad_cnt_nxt   = '0;
                            w_point_cnt_nxt = '0;
                            w_state_nxt     = S_POINT;
                        end
                        if (w_miss_p1) begin
                            w_score_p2_nxt = w_inc_p2;
                            if (w_inc_p2 == c_LIMIT) begin
                                w_state_nxt  = S_GAME_OVER;
                                w_winner_nxt = 2'b10;
                            end
                        end else if (w_miss_p2) begin
                            w_score_p1_nxt = w_inc_p1;
                            if (w_inc_p1 == c_LIMIT) begin
                                w_state_nxt  = S_GAME_OVER;
                                w_winner_nxt = 2'b01;
                            end
                        end
                    end
                end
            end
            S_POINT: begin
                if (i_Frame_Start) begin
                    if (r_point_cnt == c_TW'(c_POINT_FRAMES - 1)) begin
                        w_state_nxt     = S_RUNNING;
                        w_ball_x_nxt    = c_X_CTR;
                        w_ball_y_nxt    = c_Y_CTR;
                        w_dir_y_nxt     = 1'b1;
                        w_ball_cnt_nxt  = '0;
                        w_pad_cnt_nxt   = '0;
                        w_point_cnt_nxt = '0;
                    end else begin
                        w_point_cnt_nxt = r_point_cnt + 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    logic [9:0] w_col_tile, w_row_tile;
    logic       w_in_active;
    assign w_col_tile  = i_Col_Count >> c_SHIFT;
    assign w_row_tile  = i_Row_Count >> c_SHIFT;
    assign w_in_active = (i_Col_Count < 10'(c_ACTIVE_COLS)) && (i_Row_Count < 10'(c_ACTIVE_ROWS));

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= S_IDLE;
            r_ball_x    <= c_X_CTR;
            r_ball_y    <= c_Y_CTR;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_p1_y      <= c_P_CTR;
            r_p2_y      <= c_P_CTR;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_winner    <= 2'b00;
            r_ball_cnt  <= '0;
            r_pad_cnt   <= '0;
            r_point_cnt <= '0;
            r_start_req <= 1'b0;
            r_draw_ball <= 1'b0;
            r_draw_p1   <= 1'b0;
            r_draw_p2   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state     <= w_state_nxt;
            r_ball_x    <= w_ball_x_nxt;
            r_ball_y    <= w_ball_y_nxt;
            r_dir_x     <= w_dir_x_nxt;
            r_dir_y     <= w_dir_y_nxt;
            r_p1_y      <= w_p1_y_nxt;
            r_p2_y      <= w_p2_y_nxt;
            r_score_p1  <= w_score_p1_nxt;
            r_score_p2  <= w_score_p2_nxt;
            r_winner    <= w_winner_nxt;
            r_ball_cnt  <= w_ball_cnt_nxt;
            r_pad_cnt   <= w_pad_cnt_nxt;
            r_point_cnt <= w_point_cnt_nxt;
            r_start_req <= w_start_req_nxt;
            r_draw_ball <= w_in_active && (r_state == S_RUNNING) &&
                           (w_col_tile == 10'(r_ball_x)) && (w_row_tile == 10'(r_ball_y));
            r_draw_p1   <= w_in_active && (w_col_tile == 10'd0) &&
                           (w_row_tile >= 10'(r_p1_y)) && (w_row_tile <= 10'(w_p1_hi));
            r_draw_p2   <= w_in_active && (w_col_tile == 10'(c_GW - 1)) &&
                           (w_row_tile >= 10'(r_p2_y)) && (w_row_tile <= 10'(w_p2_hi));
        end
    end

    assign o_Draw_Ball      = r_draw_ball;
    assign o_Draw_Paddle_P1 = r_draw_p1;
    assign o_Draw_Paddle_P2 = r_draw_p2;
    assign o_Score_P1       = r_score_p1;
    assign o_Score_P2       = r_score_p2;
    assign o_State          = r_state;
    assign o_Winner         = r_winner;
endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: match flow, paddles, CPU mode, score limit,
// draw-flag sweep and asynchronous reset, against hand-computed expectations.
module tb_pong_match_ctrl;
    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       frame_start = 1'b0;
    logic [9:0] col = '0;
    logic [9:0] row = '0;
    logic       game_start = 1'b0;
    logic       mode = 1'b0;
    logic       up1 = 1'b0, dn1 = 1'b0, up2 = 1'b0, dn2 = 1'b0;
    logic       draw_ball, draw_p1, draw_p2;
    logic [3:0] score_p1, score_p2;
    logic [1:0] state, winner;

    int n_checks = 0;
    int n_errors = 0;
    int bx, by, top, cnt, n;

    pong_match_ctrl dut (
        .i_Clk            (clk),
        .i_Rst_L          (rst_l),
        .i_Frame_Start    (frame_start),
        .i_Col_Count      (col),
        .i_Row_Count      (row),
        .i_Game_Start     (game_start),
        .i_Mode           (mode),
        .i_Paddle_Up_P1   (up1),
        .i_Paddle_Dn_P1   (dn1),
        .i_Paddle_Up_P2   (up2),
        .i_Paddle_Dn_P2   (dn2),
        .o_Draw_Ball      (draw_ball),
        .o_Draw_Paddle_P1 (draw_p1),
        .o_Draw_Paddle_P2 (draw_p2),
        .o_Score_P1       (score_p1),
        .o_Score_P2       (score_p2),
        .o_State          (state),
        .o_Winner         (winner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, want);
        end
    endtask

    task automatic frame_pulse(input logic start);
        @(negedge clk);
        frame_start = 1'b1;
        game_start  = start;
        @(negedge clk);
        frame_start = 1'b0;
        game_start  = 1'b0;
    endtask

    task automatic frames(input int k);
        repeat (k) frame_pulse(1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_l = 1'b0;
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    // Scan one pixel per tile; returns -1/-1 when the ball is not drawn.
    task automatic find_ball(output int x, output int y);
        x = -1;
        y = -1;
        for (int ty = 0; ty < 30; ty++) begin
            for (int tx = 0; tx < 40; tx++) begin
                @(negedge clk);
                col = 10'(tx * 16 + 5);
                row = 10'(ty * 16 + 9);
                @(posedge clk);
                #1;
                if (draw_ball) begin
                    x = tx;
                    y = ty;
                end
            end
        end
    endtask

    task automatic paddle_span(input logic p2, output int t, output int c);
        t = -1;
        c = 0;
        for (int ty = 0; ty < 30; ty++) begin
            @(negedge clk);
            col = p2 ? 10'(39 * 16 + 8) : 10'd8;
            row = 10'(ty * 16 + 4);
            @(posedge clk);
            #1;
            if (p2 ? draw_p2 : draw_p1) begin
                if (t < 0) t = ty;
                c++;
            end
        end
    endtask

    task automatic pixel(input int c, input int r, output logic b, output logic d1, output logic d2);
        @(negedge clk);
        col = 10'(c);
        row = 10'(r);
        @(posedge clk);
        #1;
        b  = draw_ball;
        d1 = draw_p1;
        d2 = draw_p2;
    endtask

    task automatic run_until_leave(input logic [1:0] st, input int budget, output int k);
        k = 0;
        while (state == st && k < budget) begin
            frame_pulse(1'b0);
            k++;
        end
    endtask

    logic b, d1, d2;
    int   errs, ones, pc, pr, have, want;

    initial begin
        col = 10'd8;
        row = 10'd200;
        #22;
        check("rst_state", state, 0);
        check("rst_score_p1", score_p1, 0);
        check("rst_score_p2", score_p2, 0);
        check("rst_winner", winner, 0);
        check("rst_draw_p1", draw_p1, 0);
        @(negedge clk);
        rst_l = 1'b1;
        @(posedge clk);
        #1;
        check("idle_draw_p1", draw_p1, 1);
        paddle_span(1'b0, top, cnt);
        check("idle_p1_top", top, 12);
        check("idle_p1_len", cnt, 6);
        paddle_span(1'b1, top, cnt);
        check("idle_p2_top", top, 12);
        find_ball(bx, by);
        check("idle_no_ball", bx, -1);

        // Serve +X/+Y, bounce off the bottom wall, miss P2 at move 19.
        frame_pulse(1'b1);
        check("start_state", state, 1);
        frames(19);
        frame_pulse(1'b1);
        frames(36);
        find_ball(bx, by);
        check("m14_x", bx, 34);
        check("m14_y", by, 29);
        frames(16);
        find_ball(bx, by);
        check("m18_x", bx, 38);
        check("m18_y", by, 25);
        check("m18_state", state, 1);
        frames(3);
        check("f75_state", state, 1);
        frames(1);
        check("miss_score_p1", score_p1, 1);
        check("miss_score_p2", score_p2, 0);
        check("miss_state", state, 2);
        find_ball(bx, by);
        check("point_no_ball", bx, -1);

        // POINT hold, with a start request that must be ignored.
        frames(29);
        frame_pulse(1'b1);
        frames(29);
        check("point_f59_state", state, 2);
        frames(1);
        check("reserve_state", state, 1);
        find_ball(bx, by);
        check("reserve_x", bx, 20);
        check("reserve_y", by, 15);
        frames(4);
        find_ball(bx, by);
        check("serve_dir_x", bx, 19);
        check("serve_dir_y", by, 16);

        // P1 paddle saturation and Up+Dn cancel.
        up1 = 1'b1;
        frames(12);
        paddle_span(1'b0, top, cnt);
        check("p1_up12", top, 6);
        frames(18);
        paddle_span(1'b0, top, cnt);
        check("p1_up30", top, 0);
        check("p1_up30_len", cnt, 6);
        up1 = 1'b0;
        dn1 = 1'b1;
        frames(4);
        paddle_span(1'b0, top, cnt);
        check("p1_dn4", top, 2);
        up1 = 1'b1;
        frames(4);
        paddle_span(1'b0, top, cnt);
        check("p1_both", top, 2);
        paddle_span(1'b1, top, cnt);
        check("p2_idle_hold", top, 12);
        up1 = 1'b0;
        dn1 = 1'b0;

        // CPU mode: P2 tracks the ball and returns it; P2 buttons are ignored.
        do_reset();
        mode = 1'b1;
        up2  = 1'b1;
        frame_pulse(1'b1);
        frames(76);
        check("cpu_f76_state", state, 1);
        check("cpu_f76_score", score_p1, 0);
        paddle_span(1'b1, top, cnt);
        check("cpu_p2_top", top, 22);
        frames(4);
        find_ball(bx, by);
        check("cpu_rebound_x", bx, 36);
        check("cpu_rebound_y", by, 23);
        check("cpu_f80_state", state, 1);
        check("cpu_f80_score_p2", score_p2, 0);
        up2  = 1'b0;
        mode = 1'b0;

        // P1 parked at 24..29 returns every serve; P2 parked at 0..5 misses every rally.
        do_reset();
        dn1 = 1'b1;
        up2 = 1'b1;
        frame_pulse(1'b1);
        for (int p = 1; p <= 9; p++) begin
            run_until_leave(2'b01, 400, n);
            check($sformatf("rally%0d_frames", p), n, (p == 1) ? 76 : 228);
            check($sformatf("rally%0d_score_p1", p), score_p1, p);
            check($sformatf("rally%0d_score_p2", p), score_p2, 0);
            if (p < 9) begin
                check($sformatf("rally%0d_state", p), state, 2);
                run_until_leave(2'b10, 100, n);
                check($sformatf("hold%0d_frames", p), n, 60);
            end
        end
        check("limit_state", state, 3);
        check("limit_winner", winner, 1);
        dn1 = 1'b0;
        up2 = 1'b0;
        frame_pulse(1'b1);
        check("restart_state", state, 1);
        check("restart_score_p1", score_p1, 0);
        check("restart_winner", winner, 0);
        paddle_span(1'b0, top, cnt);
        check("restart_p1_top", top, 12);
        paddle_span(1'b1, top, cnt);
        check("restart_p2_top", top, 12);

        // Pixel sweep around the centred ball: output lags the pixel by one cycle.
        errs = 0;
        ones = 0;
        have = 0;
        pc   = 0;
        pr   = 0;
        for (int r = 232; r < 264; r++) begin
            for (int c = 312; c < 344; c++) begin
                @(posedge clk);
                #1;
                col = 10'(c);
                row = 10'(r);
                @(negedge clk);
                if (have != 0) begin
                    want = (pc >= 320 && pc <= 335 && pr >= 240 && pr <= 255) ? 1 : 0;
                    if (int'(draw_ball) != want) errs++;
                    if (draw_ball) ones++;
                end
                pc   = c;
                pr   = r;
                have = 1;
            end
        end
        check("sweep_ball_errs", errs, 0);
        check("sweep_ball_pixels", ones, 256);
        pixel(639, 200, b, d1, d2);
        check("col639_p2", d2, 1);
        pixel(640, 200, b, d1, d2);
        check("col640_p2", d2, 0);
        pixel(1023, 200, b, d1, d2);
        check("col1023_any", {b, d1, d2}, 0);
        pixel(8, 480, b, d1, d2);
        check("row480_any", {b, d1, d2}, 0);

        // Asynchronous reset in the middle of a POINT hold.
        frames(76);
        check("pre_rst_state", state, 2);
        check("pre_rst_score", score_p1, 1);
        frames(10);
        pixel(8, 200, b, d1, d2);
        check("pre_rst_draw_p1", d1, 1);
        @(posedge clk);
        #3;
        rst_l = 1'b0;
        #1;
        check("async_state", state, 0);
        check("async_score_p1", score_p1, 0);
        check("async_score_p2", score_p2, 0);
        check("async_winner", winner, 0);
        check("async_draw", {draw_ball, draw_p1, draw_p2}, 0);
        @(negedge clk);
        rst_l = 1'b1;
        paddle_span(1'b1, top, cnt);
        check("post_rst_p2_top", top, 12);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
